// File: rtl/router_fifo_pkg.sv
// Shared widths, error-bit positions and defaults for the router input-port FIFOs.
package router_fifo_pkg;

    localparam int FLIT_W_DEF  = 8;
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_UDF_BIT = 1;
    localparam int ERR_W       = 2;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo_ctrl_if.sv
// Write/read request and status bundle of the multi-VC input FIFO.
interface vc_fifo_ctrl_if
    import router_fifo_pkg::*;
#(
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 5,
    parameter int DATA_W = FLIT_W_DEF
);
    localparam int VC_W  = width_of(NUM_VC);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    wr_en;
    logic [VC_W-1:0]         wr_vc;
    logic [DATA_W-1:0]       wr_data;
    logic                    rd_en;
    logic [VC_W-1:0]         rd_vc;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic [NUM_VC-1:0]       full;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC-1:0]       afull;
    logic [NUM_VC*CNT_W-1:0] count;
    logic                    ovf_err;
    logic                    udf_err;

    modport master (
        output wr_en, wr_vc, wr_data, rd_en, rd_vc,
        input  rd_data, rd_valid, full, empty, afull, count, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_vc, wr_data, rd_en, rd_vc,
        output rd_data, rd_valid, full, empty, afull, count, ovf_err, udf_err
    );
endinterface

// File: rtl/vc_fifo_chan_ptr.sv
// Pointers, occupancy and flags of one virtual channel; hit strobes are pre-qualified.
module vc_fifo_chan_ptr #(
    parameter int DEPTH    = 5,
    parameter int AFULL_TH = 4,
    parameter int PTR_W    = 3,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic             rd_hit,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] rptr,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty,
    output logic             afull
);
    // Explicit wrap compare keeps non-power-of-two depths exact.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_hit) wptr <= ptr_next(wptr);
            if (rd_hit) rptr <= ptr_next(rptr);
            if (wr_hit && !rd_hit)      cnt <= cnt + CNT_W'(1);
            else if (rd_hit && !wr_hit) cnt <= cnt - CNT_W'(1);
        end
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign afull = (cnt >= CNT_W'(AFULL_TH));
endmodule

// File: rtl/vc_fifo_ctrl.sv
// Multi-VC input FIFO: request decode, banked storage, registered read port, sticky errors.
module vc_fifo_ctrl
    import router_fifo_pkg::*;
#(
    parameter int NUM_VC   = 4,
    parameter int DEPTH    = 5,
    parameter int DATA_W   = FLIT_W_DEF,
    parameter int AFULL_TH = 4
) (
    input  logic          clk,
    input  logic          rst,
    vc_fifo_ctrl_if.slave bus
);
    localparam int VC_W  = width_of(NUM_VC);
    localparam int PTR_W = width_of(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wptr_a [NUM_VC];
    logic [PTR_W-1:0]  rptr_a [NUM_VC];
    logic [CNT_W-1:0]  cnt_a  [NUM_VC];
    logic [NUM_VC-1:0] full_v, empty_v, afull_v;
    logic [NUM_VC-1:0] wr_hit, rd_hit;

    logic              wr_in, rd_in, wr_ok, rd_ok;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic [ERR_W-1:0]  err_q;

    assign wr_in = (32'(bus.wr_vc) < NUM_VC);
    assign rd_in = (32'(bus.rd_vc) < NUM_VC);
    assign rd_ok = bus.rd_en && rd_in && !empty_v[bus.rd_vc];
    // A full channel still takes a write when the same cycle frees a slot in it.
    assign wr_ok = bus.wr_en && wr_in &&
                   (!full_v[bus.wr_vc] || (rd_ok && (bus.rd_vc == bus.wr_vc)));

    for (genvar i = 0; i < NUM_VC; i++) begin : g_chan
        assign wr_hit[i] = wr_ok && (bus.wr_vc == VC_W'(i));
        assign rd_hit[i] = rd_ok && (bus.rd_vc == VC_W'(i));

        vc_fifo_chan_ptr #(
            .DEPTH    (DEPTH),
            .AFULL_TH (AFULL_TH),
            .PTR_W    (PTR_W),
            .CNT_W    (CNT_W)
        ) u_ptr (
            .clk    (clk),
            .rst    (rst),
            .wr_hit (wr_hit[i]),
            .rd_hit (rd_hit[i]),
            .wptr   (wptr_a[i]),
            .rptr   (rptr_a[i]),
            .cnt    (cnt_a[i]),
            .full   (full_v[i]),
            .empty  (empty_v[i]),
            .afull  (afull_v[i])
        );

        assign bus.count[i*CNT_W +: CNT_W] = cnt_a[i];
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[bus.wr_vc][wptr_a[bus.wr_vc]] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok)               rd_data_q <= mem[bus.rd_vc][rptr_a[bus.rd_vc]];
            if (bus.wr_en && !wr_ok) err_q[ERR_OVF_BIT] <= 1'b1;
            if (bus.rd_en && !rd_ok) err_q[ERR_UDF_BIT] <= 1'b1;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_v;
    assign bus.empty    = empty_v;
    assign bus.afull    = afull_v;
    assign bus.ovf_err  = err_q[ERR_OVF_BIT];
    assign bus.udf_err  = err_q[ERR_UDF_BIT];
endmodule

// File: tb/tb_vc_fifo_ctrl.sv
// Directed bench for vc_fifo_ctrl with the default 4 VC x 5 entry x 8 bit geometry.
module tb_vc_fifo_ctrl;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    vc_fifo_ctrl_if #(.NUM_VC(4), .DEPTH(5), .DATA_W(8)) bus ();

    vc_fifo_ctrl #(.NUM_VC(4), .DEPTH(5), .DATA_W(8), .AFULL_TH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] wv, input logic [7:0] wd,
                         input logic re, input logic [1:0] rv);
        bus.wr_en   = we;
        bus.wr_vc   = wv;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_vc   = rv;
    endtask

    function automatic logic [31:0] cnt_of(input int i);
        return 32'(bus.count[i*CW +: CW]);
    endfunction

    initial begin
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);

        // reset, then idle
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_empty", 32'(bus.empty), 32'hF);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_afull", 32'(bus.afull), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_ovf", 32'(bus.ovf_err), 32'h0);
        chk("rst_udf", 32'(bus.udf_err), 32'h0);

        // fill VC2 to the top and overflow it
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd2, 8'hA1 + 8'(k), 1'b0, 2'd0);
            cyc();
            chk("vc2_fill_cnt", cnt_of(2), 32'(k + 1));
            chk("vc2_fill_afull", 32'(bus.afull[2]), (k >= 3) ? 32'h1 : 32'h0);
            chk("vc2_fill_full", 32'(bus.full[2]), (k == 4) ? 32'h1 : 32'h0);
        end
        chk("vc2_ovf_before", 32'(bus.ovf_err), 32'h0);
        drive(1'b1, 2'd2, 8'hA6, 1'b0, 2'd0);
        cyc();
        chk("vc2_ovf", 32'(bus.ovf_err), 32'h1);
        chk("vc2_ovf_cnt", cnt_of(2), 32'h5);

        // drain VC2 in order and underflow it
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
            cyc();
            chk("vc2_rd_valid", 32'(bus.rd_valid), 32'h1);
            chk("vc2_rd_data", 32'(bus.rd_data), 32'hA1 + 32'(k));
        end
        chk("vc2_empty", 32'(bus.empty[2]), 32'h1);
        chk("vc2_udf_before", 32'(bus.udf_err), 32'h0);
        cyc();
        chk("vc2_udf", 32'(bus.udf_err), 32'h1);
        chk("vc2_udf_valid", 32'(bus.rd_valid), 32'h0);
        chk("vc2_udf_hold", 32'(bus.rd_data), 32'hA5);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        cyc();
        chk("idle_valid", 32'(bus.rd_valid), 32'h0);
        chk("ovf_sticky", 32'(bus.ovf_err), 32'h1);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("err_clr_ovf", 32'(bus.ovf_err), 32'h0);
        chk("err_clr_udf", 32'(bus.udf_err), 32'h0);

        // VC1 full, then concurrent write+read across the pointer wrap
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'd1, 8'hB1 + 8'(k), 1'b0, 2'd0);
            cyc();
        end
        chk("vc1_full", 32'(bus.full[1]), 32'h1);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 2'd1, 8'hB6 + 8'(k), 1'b1, 2'd1);
            cyc();
            chk("vc1_rw_data", 32'(bus.rd_data), 32'hB1 + 32'(k));
            chk("vc1_rw_valid", 32'(bus.rd_valid), 32'h1);
            chk("vc1_rw_cnt", cnt_of(1), 32'h5);
        end
        chk("vc1_rw_ovf", 32'(bus.ovf_err), 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
            cyc();
            chk("vc1_drain_data", 32'(bus.rd_data), 32'hB8 + 32'(k));
        end
        chk("vc1_drain_empty", 32'(bus.empty[1]), 32'h1);

        // independent channels in one cycle
        drive(1'b1, 2'd3, 8'hD0, 1'b0, 2'd0);
        cyc();
        drive(1'b1, 2'd0, 8'hC0, 1'b1, 2'd3);
        cyc();
        chk("split_cnt0", cnt_of(0), 32'h1);
        chk("split_cnt3", cnt_of(3), 32'h0);
        chk("split_data", 32'(bus.rd_data), 32'hD0);
        chk("split_valid", 32'(bus.rd_valid), 32'h1);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        cyc();
        chk("vc0_drain", 32'(bus.rd_data), 32'hC0);
        chk("udf_clean", 32'(bus.udf_err), 32'h0);

        // empty VC0: same-cycle write is accepted, read is not bypassed
        drive(1'b1, 2'd0, 8'hC1, 1'b1, 2'd0);
        cyc();
        chk("nobyp_udf", 32'(bus.udf_err), 32'h1);
        chk("nobyp_valid", 32'(bus.rd_valid), 32'h0);
        chk("nobyp_cnt0", cnt_of(0), 32'h1);
        chk("nobyp_hold", 32'(bus.rd_data), 32'hC0);

        // partly fill the rest, launch a read, then reset over it
        drive(1'b1, 2'd1, 8'hE1, 1'b0, 2'd0); cyc();
        drive(1'b1, 2'd2, 8'hE2, 1'b0, 2'd0); cyc();
        drive(1'b1, 2'd3, 8'hE3, 1'b1, 2'd0); cyc();
        chk("pre_rst_valid", 32'(bus.rd_valid), 32'h1);
        chk("pre_rst_data", 32'(bus.rd_data), 32'hC1);
        chk("pre_rst_count", 32'(bus.count), {20'h0, 3'd1, 3'd1, 3'd1, 3'd0});
        drive(1'b1, 2'd1, 8'hEE, 1'b1, 2'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        chk("mid_rst_count", 32'(bus.count), 32'h0);
        chk("mid_rst_valid", 32'(bus.rd_valid), 32'h0);
        chk("mid_rst_data", 32'(bus.rd_data), 32'h0);
        chk("mid_rst_empty", 32'(bus.empty), 32'hF);
        chk("mid_rst_udf", 32'(bus.udf_err), 32'h0);
        chk("mid_rst_ovf", 32'(bus.ovf_err), 32'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
        cyc();
        chk("post_rst_rd_rej", 32'(bus.rd_valid), 32'h0);
        chk("post_rst_udf", 32'(bus.udf_err), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
